uart_tx_buffered: RTL and testbench

Buffered UART transmitter that sends 8-bit frames on the BL616 UART TX line: 8 data bits, LSB first, optional parity, 1 or 2 stop bits. A valid/ready byte interface feeds an internal FIFO. The FIFO lets host-bound responses (banners, status bytes, echoed data) be queued in bursts without per-byte handshaking against the line rate. It sits between the loopback/command logic and the BL616_UART_TX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 72 +++++++
 rtl/uart_tx_buffered.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period calculation and
// parity-mode constants. Shared by the transmitter and a future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Clocks per serial bit; integer divide, the remainder is dropped.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output: dout always shows
// the head entry, so a pop and the read of that entry happen in one cycle.
// DEPTH must be a power of two; pointers wrap naturally.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    // A push into a full FIFO is refused even when a pop happens the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer and occupancy values.
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset; occupancy is tracked by count_q, so stale entries are never observed and the array can map to RAM.
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes enter a FIFO through a valid/ready port
// and are serialised as start, 8 data bits LSB first, optional parity and
// 1 or 2 stop bits. The line, done pulse and busy flag are registered, so
// they trail the FSM state by one clock and the pin never glitches.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_tx_done
);

    localparam int            CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int            BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST    = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST    = 3'(STOP_BITS - 1);
    localparam logic          PAR_INSERT   = (PARITY_EN != 0);
    localparam logic          PAR_SENSE    = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          done_q;
    logic          busy_q, busy_d;

    logic          bit_end;
    logic          frame_end;
    logic          load;
    logic          fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;

    assign o_ready = !fifo_full;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_valid && o_ready),
        .pop   (fifo_pop),
        .din   (i_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fifo_count)
    );

    assign bit_end = (baud_q == BAUD_LAST);

    // Next-state logic: bit timing, shifting and popping the next byte.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        frame_end = 1'b0;
        load      = 1'b0;

        if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PAR_INSERT ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        // Last clock of the frame: chain straight into the next start bit if data waits.
                        frame_end = 1'b1;
                        if (!fifo_empty) load = 1'b1;
                        else             state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d = ST_START;
            shift_d = fifo_dout;
            par_d   = (^fifo_dout) ^ PAR_SENSE;
            bit_d   = '0;
            baud_d  = '0;
        end
    end

    assign fifo_pop = load;

    // Line level for the current state; registered below.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    assign busy_d = (state_q != ST_IDLE) || !fifo_empty;

    // FSM, counters and registered outputs; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= frame_end;
            busy_q  <= busy_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_done = done_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered. Stimulus queues the expected
// frame description; a line monitor decodes each frame on the selected DUT
// instance and compares waveform, data, parity, done pulse and gaps.
module tb_uart_tx_buffered;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_bit;
        int         stop;
        int         cpb;
        logic       b2b;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  tb_data;
    logic        tb_valid;
    logic [2:0]  sel;
    logic        mon_en;

    logic [4:0]  tx_w, done_w, ready_w, busy_w;
    logic [4:0]  cnt_w [5];

    logic        mon_tx, mon_done, mon_ready, mon_busy;
    logic [4:0]  mon_cnt;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        mon_in_frame = 1'b0;
    int          last_done_cyc = 0;
    int          busy_fall_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // 0: 8N1 defaults, 1: even parity, 2: odd parity, 3: two stop bits, 4: 10 clks/bit
    uart_tx_buffered u_def (
        .clk(clk), .rst_n(rst_n), .i_data(tb_data), .i_valid(tb_valid && sel == 3'd0),
        .o_ready(ready_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]),
        .o_fifo_count(cnt_w[0]), .o_tx_done(done_w[0])
    );
    uart_tx_buffered #(.PARITY_EN(1), .PARITY_ODD(0)) u_pe (
        .clk(clk), .rst_n(rst_n), .i_data(tb_data), .i_valid(tb_valid && sel == 3'd1),
        .o_ready(ready_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]),
        .o_fifo_count(cnt_w[1]), .o_tx_done(done_w[1])
    );
    uart_tx_buffered #(.PARITY_EN(1), .PARITY_ODD(1)) u_po (
        .clk(clk), .rst_n(rst_n), .i_data(tb_data), .i_valid(tb_valid && sel == 3'd2),
        .o_ready(ready_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]),
        .o_fifo_count(cnt_w[2]), .o_tx_done(done_w[2])
    );
    uart_tx_buffered #(.STOP_BITS(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .i_data(tb_data), .i_valid(tb_valid && sel == 3'd3),
        .o_ready(ready_w[3]), .o_tx(tx_w[3]), .o_busy(busy_w[3]),
        .o_fifo_count(cnt_w[3]), .o_tx_done(done_w[3])
    );
    uart_tx_buffered #(.CLK_FREQ(100), .BAUD_RATE(10)) u_fast (
        .clk(clk), .rst_n(rst_n), .i_data(tb_data), .i_valid(tb_valid && sel == 3'd4),
        .o_ready(ready_w[4]), .o_tx(tx_w[4]), .o_busy(busy_w[4]),
        .o_fifo_count(cnt_w[4]), .o_tx_done(done_w[4])
    );

    always_comb begin
        mon_tx    = tx_w[sel];
        mon_done  = done_w[sel];
        mon_ready = ready_w[sel];
        mon_busy  = busy_w[sel];
        mon_cnt   = cnt_w[sel];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic pb,
                                input int stop, input int cpb, input logic b2b);
        exp_t e;
        e.data = d; e.par_en = pe; e.par_bit = pb; e.stop = stop; e.cpb = cpb; e.b2b = b2b;
        return e;
    endfunction

    task automatic push1(input logic [7:0] d);
        @(negedge clk);
        tb_data  = d;
        tb_valid = 1'b1;
        @(negedge clk);
        tb_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < budget), 1);
    endtask

    // Line monitor: decodes one frame per expected entry.
    initial begin : monitor
        exp_t       e;
        int         idle = 0;
        int         len, b, wave_err, done_err;
        logic       lvl, par_cap;
        logic [7:0] cap;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                idle = 0;
            end else if (mon_tx === 1'b1) begin
                idle++;
            end else if (exp_q.size() == 0) begin
                check("unexpected_frame", 1, 0);
                idle = 0;
            end else begin
                mon_in_frame = 1'b1;
                e = exp_q.pop_front();
                if (e.b2b) check("frame_gap", idle, 0);
                len = (9 + int'(e.par_en) + e.stop) * e.cpb;
                wave_err = 0; done_err = 0; cap = '0; par_cap = 1'b0;
                for (int i = 0; i < len; i++) begin
                    if (i > 0) @(negedge clk);
                    b = i / e.cpb;
                    if (b == 0)                     lvl = 1'b0;
                    else if (b <= 8)                lvl = e.data[b-1];
                    else if (b == 9 && e.par_en)    lvl = e.par_bit;
                    else                            lvl = 1'b1;
                    if (mon_tx !== lvl) wave_err++;
                    if ((i % e.cpb) == e.cpb / 2) begin
                        if (b >= 1 && b <= 8)           cap[b-1] = mon_tx;
                        if (b == 9 && e.par_en)         par_cap  = mon_tx;
                    end
                    if (mon_done !== (i == len - 1)) done_err++;
                    if (mon_done === 1'b1) last_done_cyc = cyc;
                end
                check("frame_data", cap, e.data);
                if (e.par_en) check("frame_parity", par_cap, e.par_bit);
                check("frame_wave", wave_err, 0);
                check("frame_done", done_err, 0);
                idle = 0;
                mon_in_frame = 1'b0;
            end
        end
    end

    // Records when o_busy of the selected instance falls.
    initial begin : busy_watch
        logic busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_prev && !mon_busy) busy_fall_cyc = cyc;
            busy_prev = mon_busy;
        end
    end

    initial begin : stimulus
        int lows;
        rst_n = 1'b0; tb_valid = 1'b0; tb_data = '0; sel = 3'd0; mon_en = 1'b1;
        #12;
        check("rst_tx", mon_tx, 1);
        check("rst_ready", mon_ready, 1);
        check("rst_busy", mon_busy, 0);
        check("rst_count", mon_cnt, 0);
        check("rst_done", mon_done, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 0x55 with accept-to-line latency
        exp_q.push_back(mk(8'h55, 1'b0, 1'b0, 1, 234, 1'b0));
        push1(8'h55);
        check("lat_count", mon_cnt, 1);
        @(negedge clk);
        check("lat_n1_tx", mon_tx, 1);
        check("lat_n1_busy", mon_busy, 1);
        @(negedge clk);
        check("lat_n2_tx", mon_tx, 0);
        wait_done(3000, "t1_timeout");
        repeat (3) @(negedge clk);
        check("t1_idle_tx", mon_tx, 1);
        check("t1_idle_busy", mon_busy, 0);

        // Even then odd parity on 0x07
        sel = 3'd1;
        repeat (2) @(negedge clk);
        exp_q.push_back(mk(8'h07, 1'b1, 1'b1, 1, 234, 1'b0));
        push1(8'h07);
        wait_done(3200, "par_even_timeout");
        sel = 3'd2;
        repeat (2) @(negedge clk);
        exp_q.push_back(mk(8'h07, 1'b1, 1'b0, 1, 234, 1'b0));
        push1(8'h07);
        wait_done(3200, "par_odd_timeout");

        // Two stop bits on 0xA3
        sel = 3'd3;
        repeat (2) @(negedge clk);
        exp_q.push_back(mk(8'hA3, 1'b0, 1'b0, 2, 234, 1'b0));
        push1(8'hA3);
        wait_done(3400, "stop2_timeout");

        // Burst of 20 valid cycles into a 16-deep FIFO, 10 clocks per bit
        sel = 3'd4;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 17; k++)
            exp_q.push_back(mk(8'hA0 + 8'(k), 1'b0, 1'b0, 1, 10, k != 0));
        tb_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tb_data = 8'hA0 + 8'(k);
            check($sformatf("burst_ready_c%0d", k), mon_ready, (k < 17) ? 1 : 0);
            @(negedge clk);
        end
        tb_valid = 1'b0;
        check("burst_count", mon_cnt, 16);
        repeat (81) @(negedge clk);
        check("burst_ready_pre_pop", mon_ready, 0);
        @(negedge clk);
        check("burst_ready_post_pop", mon_ready, 1);
        check("burst_count_post_pop", mon_cnt, 15);
        wait_done(2500, "burst_timeout");

        // 0xFF then 0x00 back to back, busy falls one clock after the last done
        sel = 3'd0;
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(8'hFF, 1'b0, 1'b0, 1, 234, 1'b0));
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1, 234, 1'b1));
        @(negedge clk); tb_data = 8'hFF; tb_valid = 1'b1;
        @(negedge clk); tb_data = 8'h00;
        @(negedge clk); tb_valid = 1'b0;
        wait_done(5500, "pair_timeout");
        repeat (3) @(negedge clk);
        check("pair_busy_fall", busy_fall_cyc - last_done_cyc, 1);

        // Reset mid-DATA with three bytes queued
        mon_en = 1'b0;
        @(negedge clk); tb_data = 8'h11; tb_valid = 1'b1;
        @(negedge clk); tb_data = 8'h22;
        @(negedge clk); tb_data = 8'h33;
        @(negedge clk); tb_data = 8'h44;
        @(negedge clk); tb_valid = 1'b0;
        check("prerst_count", mon_cnt, 3);
        repeat (900) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_tx", mon_tx, 1);
        check("midrst_count", mon_cnt, 0);
        check("midrst_busy", mon_busy, 0);
        check("midrst_ready", mon_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        lows = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (mon_tx !== 1'b1) lows++;
        end
        check("postrst_line_lows", lows, 0);
        check("postrst_count", mon_cnt, 0);
        check("postrst_busy", mon_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
